// File: rtl/scpad_types_pkg.sv
// Shared scratchpad/DRAM types: line and beat geometry plus the DRAM write
// request bundle used by the writeback serializer and the DRAM arbiter.
package scpad_types_pkg;

    localparam int LINE_W     = 512;
    localparam int BEAT_W     = 64;
    localparam int MAX_BEATS  = LINE_W / BEAT_W;
    localparam int ADDR_W     = 32;
    localparam int ID_W       = 8;
    localparam int BEAT_IDX_W = $clog2(MAX_BEATS);

    typedef logic [LINE_W-1:0] scpad_data_t;

    typedef struct packed {
        logic              valid;
        logic              write;
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [BEAT_W-1:0] wdata;
        logic              last;
    } dram_write_req_t;

endpackage

// File: rtl/dram_write_req_if.sv
// SRAM line input and DRAM write request channel of the writeback serializer.
interface dram_write_req_if #(
    parameter int LINE_W = scpad_types_pkg::LINE_W,
    parameter int BEAT_W = scpad_types_pkg::BEAT_W,
    parameter int ADDR_W = scpad_types_pkg::ADDR_W,
    parameter int ID_W   = scpad_types_pkg::ID_W,
    parameter int IDX_W  = scpad_types_pkg::BEAT_IDX_W
);

    logic              line_valid;
    logic              line_ready;
    logic [LINE_W-1:0] line_data;
    logic [ID_W-1:0]   line_id;
    logic [ADDR_W-1:0] line_addr;
    logic [IDX_W-1:0]  num_request;
    logic              be_stall;
    logic              dram_req_valid;
    logic              dram_req_ready;
    logic              dram_req_write;
    logic [ID_W-1:0]   dram_req_id;
    logic [ADDR_W-1:0] dram_req_addr;
    logic [BEAT_W-1:0] dram_wdata;
    logic              dram_req_last;
    logic              busy;

    modport dram_write_serializer (
        input  line_valid,
        output line_ready,
        input  line_data,
        input  line_id,
        input  line_addr,
        input  num_request,
        input  be_stall,
        output dram_req_valid,
        input  dram_req_ready,
        output dram_req_write,
        output dram_req_id,
        output dram_req_addr,
        output dram_wdata,
        output dram_req_last,
        output busy
    );

    // Upstream/DRAM side: supplies lines and the DRAM ready, observes beats.
    modport master (
        output line_valid,
        input  line_ready,
        output line_data,
        output line_id,
        output line_addr,
        output num_request,
        output be_stall,
        input  dram_req_valid,
        output dram_req_ready,
        input  dram_req_write,
        input  dram_req_id,
        input  dram_req_addr,
        input  dram_wdata,
        input  dram_req_last,
        input  busy
    );

endinterface

// File: rtl/beat_mux.sv
// Combinational selector picking one BEAT_W slice of a scratchpad line.
module beat_mux #(
    parameter int BEAT_W    = 64,
    parameter int MAX_BEATS = 8,
    parameter int IDX_W     = $clog2(MAX_BEATS)
) (
    input  logic [BEAT_W*MAX_BEATS-1:0] line_data,
    input  logic [IDX_W-1:0]            beat_idx,
    output logic [BEAT_W-1:0]           beat
);

    always_comb begin
        beat = '0;
        for (int k = 0; k < MAX_BEATS; k++) begin
            if (beat_idx == k[IDX_W-1:0]) begin
                beat = line_data[k*BEAT_W +: BEAT_W];
            end
        end
    end

endmodule

// File: rtl/dram_write_serializer.sv
// Writeback serializer: latches one scratchpad line and issues it to DRAM as
// a burst of 64-bit write beats, chaining lines with no idle cycle between them.
module dram_write_serializer #(
    parameter int LINE_W    = scpad_types_pkg::LINE_W,
    parameter int BEAT_W    = scpad_types_pkg::BEAT_W,
    parameter int MAX_BEATS = scpad_types_pkg::MAX_BEATS,
    parameter int ADDR_W    = scpad_types_pkg::ADDR_W
) (
    input  logic clk,
    input  logic rst,
    dram_write_req_if.dram_write_serializer bus
);

    import scpad_types_pkg::dram_write_req_t;

    localparam int IDX_W = $clog2(MAX_BEATS);
    localparam int ID_W  = 8;

    typedef enum logic [0:0] {
        IDLE,
        SEND
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  beat_idx;
    logic [IDX_W-1:0]  beat_idx_next;
    logic              load;

    logic [LINE_W-1:0] lat_data;
    logic [ID_W-1:0]   lat_id;
    logic [ADDR_W-1:0] lat_addr;
    logic [IDX_W-1:0]  lat_num;

    logic              sending;
    logic              beat_last;
    logic              beat_fire;
    logic              accept;
    logic [BEAT_W-1:0] mux_beat;
    dram_write_req_t   req;

    assign sending   = (state == SEND);
    assign beat_last = sending && (beat_idx == lat_num);
    assign beat_fire = sending && bus.dram_req_ready && !bus.be_stall;

    // A new line may slip in on the very cycle the last beat leaves.
    assign bus.line_ready = !bus.be_stall &&
                            ((state == IDLE) || (beat_last && bus.dram_req_ready));
    assign accept = bus.line_valid && bus.line_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            beat_idx <= '0;
        end else begin
            state    <= state_next;
            beat_idx <= beat_idx_next;
        end
    end

    always_comb begin
        state_next    = state;
        beat_idx_next = beat_idx;
        load          = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next    = SEND;
                    beat_idx_next = '0;
                    load          = 1'b1;
                end
            end
            SEND: begin
                if (beat_fire) begin
                    if (beat_last) begin
                        beat_idx_next = '0;
                        if (accept) begin
                            load = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        beat_idx_next = beat_idx + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_data <= '0;
            lat_id   <= '0;
            lat_addr <= '0;
            lat_num  <= '0;
        end else if (load) begin
            lat_data <= bus.line_data;
            lat_id   <= bus.line_id;
            lat_addr <= bus.line_addr;
            lat_num  <= bus.num_request;
        end
    end

    beat_mux #(
        .BEAT_W    (BEAT_W),
        .MAX_BEATS (MAX_BEATS),
        .IDX_W     (IDX_W)
    ) u_beat_mux (
        .line_data (lat_data),
        .beat_idx  (beat_idx),
        .beat      (mux_beat)
    );

    // Beat fields are forced to zero outside SEND; address wraps modulo 2^ADDR_W.
    always_comb begin
        req       = '0;
        req.valid = sending;
        req.write = sending;
        req.last  = beat_last;
        if (sending) begin
            req.id    = lat_id;
            req.addr  = lat_addr + ADDR_W'({beat_idx, 3'b000});
            req.wdata = mux_beat;
        end
    end

    assign bus.dram_req_valid = req.valid;
    assign bus.dram_req_write = req.write;
    assign bus.dram_req_id    = req.id;
    assign bus.dram_req_addr  = req.addr;
    assign bus.dram_wdata     = req.wdata;
    assign bus.dram_req_last  = req.last;
    assign bus.busy           = (state != IDLE);

endmodule

// File: tb/tb_dram_write_serializer.sv
// Directed bench for dram_write_serializer: full/short lines, backpressure,
// stall, back-to-back chaining, address wrap and reset mid-line.
module tb_dram_write_serializer;

    logic clk = 1'b0;
    logic rst;
    int   check_count = 0;
    int   pass_count  = 0;

    always #5 clk = ~clk;

    dram_write_req_if bus ();

    dram_write_serializer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [63:0] beat_a(input int k);
        logic [3:0] n;
        n = 4'(k);
        return {16{n}};
    endfunction

    function automatic logic [63:0] beat_b(input int k);
        return {16'hBEEF, 40'h0, 8'(k)};
    endfunction

    function automatic logic [511:0] line_a();
        logic [511:0] l;
        for (int k = 0; k < 8; k++) l[k*64 +: 64] = beat_a(k);
        return l;
    endfunction

    function automatic logic [511:0] line_b();
        logic [511:0] l;
        for (int k = 0; k < 8; k++) l[k*64 +: 64] = beat_b(k);
        return l;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic check_beat(input string tag, input logic [7:0] id, input logic [31:0] addr,
                              input logic [63:0] wdata, input logic last);
        check_output({tag, ".valid"}, 64'(bus.dram_req_valid), 64'd1);
        check_output({tag, ".write"}, 64'(bus.dram_req_write), 64'd1);
        check_output({tag, ".id"},    64'(bus.dram_req_id),    64'(id));
        check_output({tag, ".addr"},  64'(bus.dram_req_addr),  64'(addr));
        check_output({tag, ".wdata"}, bus.dram_wdata,           wdata);
        check_output({tag, ".last"},  64'(bus.dram_req_last),  64'(last));
        check_output({tag, ".busy"},  64'(bus.busy),           64'd1);
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, ".valid"}, 64'(bus.dram_req_valid), 64'd0);
        check_output({tag, ".write"}, 64'(bus.dram_req_write), 64'd0);
        check_output({tag, ".id"},    64'(bus.dram_req_id),    64'd0);
        check_output({tag, ".addr"},  64'(bus.dram_req_addr),  64'd0);
        check_output({tag, ".wdata"}, bus.dram_wdata,           64'd0);
        check_output({tag, ".last"},  64'(bus.dram_req_last),  64'd0);
        check_output({tag, ".busy"},  64'(bus.busy),           64'd0);
    endtask

    task automatic apply_stimulus(input logic valid, input logic [511:0] data, input logic [7:0] id,
                                  input logic [31:0] addr, input logic [2:0] num);
        bus.line_valid  = valid;
        bus.line_data   = data;
        bus.line_id     = id;
        bus.line_addr   = addr;
        bus.num_request = num;
    endtask

    task automatic apply_idle_line();
        apply_stimulus(1'b0, {8{64'hDEAD_BEEF_DEAD_BEEF}}, 8'hEE, 32'hDEAD_0000, 3'd5);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Safety net so the run always ends even if the stimulus stalls.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: observed no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [6:0] ready_pat;
        int         exp_idx;

        rst                = 1'b1;
        bus.be_stall       = 1'b0;
        bus.dram_req_ready = 1'b0;
        apply_idle_line();

        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        check_output("reset.line_ready", 64'(bus.line_ready), 64'd1);
        rst = 1'b0;
        next_cycle();
        check_idle("post_reset");

        $display("[TB] full line, 8 beats");
        bus.dram_req_ready = 1'b1;
        apply_stimulus(1'b1, line_a(), 8'h11, 32'h0000_1000, 3'd7);
        #1;
        check_output("full.line_ready_idle", 64'(bus.line_ready), 64'd1);
        next_cycle();
        apply_idle_line();
        for (int k = 0; k < 8; k++) begin
            check_beat($sformatf("full.b%0d", k), 8'h11, 32'h0000_1000 + 32'(8 * k),
                       beat_a(k), k == 7);
            if (k == 3) check_output("full.line_ready_mid", 64'(bus.line_ready), 64'd0);
            if (k == 7) check_output("full.line_ready_last", 64'(bus.line_ready), 64'd1);
            next_cycle();
        end
        check_idle("full.done");

        $display("[TB] short line, 1 beat");
        apply_stimulus(1'b1, line_a(), 8'h22, 32'h0000_2000, 3'd0);
        next_cycle();
        apply_idle_line();
        check_beat("short.b0", 8'h22, 32'h0000_2000, beat_a(0), 1'b1);
        next_cycle();
        check_idle("short.done");

        $display("[TB] backpressure");
        bus.dram_req_ready = 1'b0;
        apply_stimulus(1'b1, line_b(), 8'h33, 32'h0000_3000, 3'd3);
        next_cycle();
        apply_idle_line();
        ready_pat = 7'b1101001;
        exp_idx   = 0;
        for (int c = 0; c < 7; c++) begin
            bus.dram_req_ready = ready_pat[c];
            #1;
            check_beat($sformatf("bp.c%0d", c), 8'h33, 32'h0000_3000 + 32'(8 * exp_idx),
                       beat_b(exp_idx), exp_idx == 3);
            next_cycle();
            if (ready_pat[c]) exp_idx++;
        end
        check_idle("bp.done");

        $display("[TB] be_stall mid-line");
        bus.dram_req_ready = 1'b1;
        apply_stimulus(1'b1, line_a(), 8'h44, 32'h0000_4000, 3'd7);
        next_cycle();
        apply_idle_line();
        check_beat("stall.b0", 8'h44, 32'h0000_4000, beat_a(0), 1'b0);
        next_cycle();
        bus.be_stall = 1'b1;
        apply_stimulus(1'b1, line_b(), 8'h99, 32'h0000_9000, 3'd0);
        #1;
        for (int s = 0; s < 3; s++) begin
            check_beat($sformatf("stall.s%0d", s), 8'h44, 32'h0000_4008, beat_a(1), 1'b0);
            check_output($sformatf("stall.s%0d.line_ready", s), 64'(bus.line_ready), 64'd0);
            next_cycle();
        end
        bus.be_stall = 1'b0;
        apply_idle_line();
        #1;
        for (int k = 1; k < 8; k++) begin
            check_beat($sformatf("stall.b%0d", k), 8'h44, 32'h0000_4000 + 32'(8 * k),
                       beat_a(k), k == 7);
            next_cycle();
        end
        check_idle("stall.done");

        $display("[TB] back-to-back lines");
        apply_stimulus(1'b1, line_a(), 8'h55, 32'h0000_5000, 3'd1);
        next_cycle();
        apply_idle_line();
        check_beat("b2b.a0", 8'h55, 32'h0000_5000, beat_a(0), 1'b0);
        next_cycle();
        check_beat("b2b.a1", 8'h55, 32'h0000_5008, beat_a(1), 1'b1);
        apply_stimulus(1'b1, line_b(), 8'h66, 32'h0000_6000, 3'd1);
        #1;
        check_output("b2b.line_ready", 64'(bus.line_ready), 64'd1);
        next_cycle();
        apply_idle_line();
        check_beat("b2b.b0", 8'h66, 32'h0000_6000, beat_b(0), 1'b0);
        next_cycle();
        check_beat("b2b.b1", 8'h66, 32'h0000_6008, beat_b(1), 1'b1);
        next_cycle();
        check_idle("b2b.done");

        $display("[TB] address wrap");
        apply_stimulus(1'b1, line_b(), 8'h77, 32'hFFFF_FFF8, 3'd1);
        next_cycle();
        apply_idle_line();
        check_beat("wrap.b0", 8'h77, 32'hFFFF_FFF8, beat_b(0), 1'b0);
        next_cycle();
        check_beat("wrap.b1", 8'h77, 32'h0000_0000, beat_b(1), 1'b1);
        next_cycle();
        check_idle("wrap.done");

        $display("[TB] reset mid-line");
        apply_stimulus(1'b1, line_a(), 8'h88, 32'h0000_7000, 3'd7);
        next_cycle();
        apply_idle_line();
        next_cycle();
        next_cycle();
        check_beat("rst.b2", 8'h88, 32'h0000_7010, beat_a(2), 1'b0);
        rst = 1'b1;
        #1;
        check_idle("rst.async");
        check_output("rst.line_ready", 64'(bus.line_ready), 64'd1);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        check_idle("rst.after1");
        next_cycle();
        check_idle("rst.after2");

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
